// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port integer register file with an integrated scoreboard.
//
// The file holds NREG x XLEN registers, has two write ports and RD_PORTS
// combinational read ports, and keeps one busy bit per register.
// Register 0 is hardwired to zero and is never marked busy.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   wen_i/waddr_i/wdata_i two write ports, packed per port (port 1 wins on collision)
//   wclr_i                the write on port p also clears busy[waddr]
//   iss_i/iss_rd_i        issue: mark the destination register busy
//   flush_i               clear every busy bit and drop a same-cycle issue
//   ren_i/raddr_i         read enable and read address, one per read port
//   rdata_o/rrdy_o        read data and operand-ready flag, one per read port
//   busy_o                raw scoreboard vector
//
// Build option: define RF_BYPASS_EN to forward same-cycle write data and
// readiness to the read ports. Without it a reader sees the new value and
// the cleared busy bit one cycle after the write.

module reg_file_sb_rd #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic                      ren,
  input  logic [AW-1:0]             raddr,
  input  logic [NREG-1:0][XLEN-1:0] regs,
  input  logic [NREG-1:0]           busy,
  input  logic                      byp_hit,
  input  logic [XLEN-1:0]           byp_data,
  output logic [XLEN-1:0]           rdata,
  output logic                      rrdy
);
  // Disabled ports and r0 read as zero and always ready.
  always_comb begin
    rdata = '0;
    rrdy  = 1'b1;
    if (ren && raddr != '0) begin
      if (byp_hit) begin
        rdata = byp_data;
        rrdy  = 1'b1;
      end else begin
        rdata = regs[raddr];
        rrdy  = ~busy[raddr];
      end
    end
  end
endmodule

module reg_file_sb #(
  parameter  int XLEN     = 64,
  parameter  int NREG     = 32,
  parameter  int RD_PORTS = 2,
  localparam int AW       = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               wen_i,
  input  logic [2*AW-1:0]          waddr_i,
  input  logic [2*XLEN-1:0]        wdata_i,
  input  logic [1:0]               wclr_i,
  input  logic                     iss_i,
  input  logic [AW-1:0]            iss_rd_i,
  input  logic                     flush_i,
  input  logic [RD_PORTS-1:0]      ren_i,
  input  logic [RD_PORTS*AW-1:0]   raddr_i,
  output logic [RD_PORTS*XLEN-1:0] rdata_o,
  output logic [RD_PORTS-1:0]      rrdy_o,
  output logic [NREG-1:0]          busy_o
);
  logic [1:0][AW-1:0]                 wa;
  logic [1:0][XLEN-1:0]               wd;
  logic [RD_PORTS-1:0][AW-1:0]        ra;
  logic [RD_PORTS-1:0][XLEN-1:0]      rd;
  logic [NREG-1:0][XLEN-1:0]          regs;
  logic [NREG-1:0]                    busy, busy_nxt;
  logic [RD_PORTS-1:0]                byp_hit;
  logic [RD_PORTS-1:0][XLEN-1:0]      byp_data;

  assign wa      = waddr_i;
  assign wd      = wdata_i;
  assign ra      = raddr_i;
  assign rdata_o = rd;
  assign busy_o  = rst_n ? busy : '0;

  // Data array. Port 1 is applied last, so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (wen_i[p] && wa[p] != '0) regs[wa[p]] <= wd[p];
    end
  end

  // Scoreboard: clears first, then the issue set, so a newer producer
  // survives a same-cycle writeback of the older one. Flush overrides both.
  always_comb begin
    busy_nxt = busy;
    for (int p = 0; p < 2; p++)
      if (wen_i[p] && wclr_i[p]) busy_nxt[wa[p]] = 1'b0;
    if (iss_i && iss_rd_i != '0) busy_nxt[iss_rd_i] = 1'b1;
    if (flush_i) busy_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

`ifdef RF_BYPASS_EN
  // Forward any enabled write whose address matches; port 1 has priority.
  // The r0 case is excluded inside the read-port instance.
  always_comb begin
    byp_hit  = '0;
    byp_data = '0;
    for (int k = 0; k < RD_PORTS; k++)
      for (int p = 0; p < 2; p++)
        if (wen_i[p] && wa[p] == ra[k]) begin
          byp_hit[k]  = 1'b1;
          byp_data[k] = wd[p];
        end
  end
`else
  assign byp_hit  = '0;
  assign byp_data = '0;
`endif

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    reg_file_sb_rd #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rd (
      .ren      (ren_i[k]),
      .raddr    (ra[k]),
      .regs     (regs),
      .busy     (busy),
      .byp_hit  (byp_hit[k]),
      .byp_data (byp_data[k]),
      .rdata    (rd[k]),
      .rrdy     (rrdy_o[k])
    );
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb (XLEN=64, NREG=32, RD_PORTS=2).
// Expectations adapt to whether RF_BYPASS_EN is defined for the build.
module tb_reg_file_sb;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int RDP  = 2;
  localparam int AW   = 5;

  logic                 clk;
  logic                 rst_n;
  logic [1:0]           wen_i;
  logic [2*AW-1:0]      waddr_i;
  logic [2*XLEN-1:0]    wdata_i;
  logic [1:0]           wclr_i;
  logic                 iss_i;
  logic [AW-1:0]        iss_rd_i;
  logic                 flush_i;
  logic [RDP-1:0]       ren_i;
  logic [RDP*AW-1:0]    raddr_i;
  logic [RDP*XLEN-1:0]  rdata_o;
  logic [RDP-1:0]       rrdy_o;
  logic [NREG-1:0]      busy_o;

  int total = 0;
  int bad   = 0;

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .RD_PORTS(RDP)) dut (
    .clk(clk), .rst_n(rst_n), .wen_i(wen_i), .waddr_i(waddr_i),
    .wdata_i(wdata_i), .wclr_i(wclr_i), .iss_i(iss_i), .iss_rd_i(iss_rd_i),
    .flush_i(flush_i), .ren_i(ren_i), .raddr_i(raddr_i), .rdata_o(rdata_o),
    .rrdy_o(rrdy_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen_i = '0; waddr_i = '0; wdata_i = '0; wclr_i = '0;
    iss_i = 1'b0; iss_rd_i = '0; flush_i = 1'b0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d, input logic clr);
    wen_i[p] = 1'b1;
    waddr_i[p*AW +: AW] = a;
    wdata_i[p*XLEN +: XLEN] = d;
    wclr_i[p] = clr;
  endtask

  task automatic rd(input int k, input logic [AW-1:0] a);
    ren_i[k] = 1'b1;
    raddr_i[k*AW +: AW] = a;
  endtask

  function automatic logic [XLEN-1:0] rdat(input int k);
    return rdata_o[k*XLEN +: XLEN];
  endfunction

  initial begin
    idle();
    rst_n = 1'b0; ren_i = '0; raddr_i = '0;
    // Reset with activity pending; it must win.
    iss_i = 1'b1; iss_rd_i = 5'd12; wr(0, 5'd12, 64'hAB, 1'b0);
    tick();
    chk("busy_in_reset", {32'h0, busy_o}, 64'h0);
    tick();
    rst_n = 1'b1; idle();
    rd(0, 5'd1); rd(1, 5'd31);
    #1;
    chk("rst_rd0", rdat(0), 64'h0);
    chk("rst_rd1", rdat(1), 64'h0);
    chk("rst_rrdy", {62'h0, rrdy_o}, 64'h3);
    chk("rst_busy", {32'h0, busy_o}, 64'h0);
    rd(0, 5'd12);
    #1;
    chk("rst_r12", rdat(0), 64'h0);

    // Issue r5, write back three cycles later.
    iss_i = 1'b1; iss_rd_i = 5'd5; rd(0, 5'd5);
    #1;
    chk("iss_same_cyc_rrdy", {63'h0, rrdy_o[0]}, 64'h1);
    tick(); idle();
    #1;
    chk("iss_n1_rrdy", {63'h0, rrdy_o[0]}, 64'h0);
    chk("iss_n1_busy", {32'h0, busy_o}, 64'h20);
    tick();
    #1;
    chk("iss_n2_rrdy", {63'h0, rrdy_o[0]}, 64'h0);
    tick();
    wr(0, 5'd5, 64'hDEAD_BEEF, 1'b1);
    #1;
`ifdef RF_BYPASS_EN
    chk("wb_n3_rdata", rdat(0), 64'hDEAD_BEEF);
    chk("wb_n3_rrdy", {63'h0, rrdy_o[0]}, 64'h1);
`else
    chk("wb_n3_rdata", rdat(0), 64'h0);
    chk("wb_n3_rrdy", {63'h0, rrdy_o[0]}, 64'h0);
`endif
    tick(); idle();
    #1;
    chk("wb_n4_rdata", rdat(0), 64'hDEAD_BEEF);
    chk("wb_n4_rrdy", {63'h0, rrdy_o[0]}, 64'h1);
    chk("wb_n4_busy", {32'h0, busy_o}, 64'h0);

    // Read enable low: zero data, ready, even for a nonzero register.
    ren_i = 2'b00;
    #1;
    chk("ren0_rdata", rdat(0), 64'h0);
    chk("ren0_rrdy", {62'h0, rrdy_o}, 64'h3);

    // Write-write collision on r7 (busy beforehand).
    iss_i = 1'b1; iss_rd_i = 5'd7;
    tick(); idle();
    wr(0, 5'd7, 64'h11, 1'b1); wr(1, 5'd7, 64'h22, 1'b1); rd(1, 5'd7);
    #1;
`ifdef RF_BYPASS_EN
    chk("coll_byp_rdata", rdat(1), 64'h22);
    chk("coll_byp_rrdy", {63'h0, rrdy_o[1]}, 64'h1);
`else
    chk("coll_old_rdata", rdat(1), 64'h0);
    chk("coll_old_rrdy", {63'h0, rrdy_o[1]}, 64'h0);
`endif
    tick(); idle();
    #1;
    chk("coll_rdata", rdat(1), 64'h22);
    chk("coll_busy", {32'h0, busy_o}, 64'h0);

    // Set beats clear on r9.
    iss_i = 1'b1; iss_rd_i = 5'd9;
    tick(); idle();
    iss_i = 1'b1; iss_rd_i = 5'd9; wr(1, 5'd9, 64'h99, 1'b1);
    tick(); idle(); rd(0, 5'd9);
    #1;
    chk("sbc_busy", {32'h0, busy_o}, 64'h200);
    chk("sbc_rdata", rdat(0), 64'h99);
    chk("sbc_rrdy", {63'h0, rrdy_o[0]}, 64'h0);

    // Flush with concurrent issue and write.
    iss_i = 1'b1; iss_rd_i = 5'd3; tick();
    iss_rd_i = 5'd4; tick();
    iss_rd_i = 5'd6; tick();
    idle();
    #1;
    chk("pre_flush_busy", {32'h0, busy_o}, 64'h258);
    flush_i = 1'b1; iss_i = 1'b1; iss_rd_i = 5'd8; wr(0, 5'd3, 64'h5, 1'b0);
    tick(); idle(); rd(0, 5'd3); rd(1, 5'd8);
    #1;
    chk("flush_busy", {32'h0, busy_o}, 64'h0);
    chk("flush_r3", rdat(0), 64'h5);
    chk("flush_rrdy", {62'h0, rrdy_o}, 64'h3);

    // Zero register.
    iss_i = 1'b1; iss_rd_i = 5'd0; wr(0, 5'd0, 64'hFFFF, 1'b1); rd(0, 5'd0); rd(1, 5'd0);
    #1;
    chk("r0_same_rdata", rdat(0), 64'h0);
    chk("r0_same_rrdy", {62'h0, rrdy_o}, 64'h3);
    tick(); idle();
    #1;
    chk("r0_busy", {32'h0, busy_o}, 64'h0);
    chk("r0_rdata", rdat(1), 64'h0);
    chk("r0_rrdy", {62'h0, rrdy_o}, 64'h3);

    // Reset mid-issue/mid-write clears everything.
    rst_n = 1'b0; iss_i = 1'b1; iss_rd_i = 5'd10; wr(0, 5'd10, 64'h77, 1'b0);
    tick();
    rst_n = 1'b1; idle(); rd(0, 5'd10); rd(1, 5'd5);
    #1;
    chk("mrst_busy", {32'h0, busy_o}, 64'h0);
    chk("mrst_r10", rdat(0), 64'h0);
    chk("mrst_r5", rdat(1), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
